// File: rtl/bptc_parity_pipe.sv
// Registered multi-channel parity pipe: NCH channels XORed against a shared pivot,
// with per-beat or frame-accumulated output, optional inversion and valid tracking.
module bptc_parity_pipe #(
    parameter int NCH       = 2,
    parameter int W         = 1,
    parameter int FRAME_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [NCH*W-1:0]             d,
    input  logic [W-1:0]                 p_in,
    input  logic                         mode,
    input  logic                         inv,
    output logic [NCH*W-1:0]             pout,
    output logic                         out_valid,
    output logic                         frame_done,
    output logic [$clog2(FRAME_LEN)-1:0] beat_cnt
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

    function automatic logic [NCH*W-1:0] beat_term(input logic [NCH*W-1:0] dv,
                                                   input logic [W-1:0] pv);
        logic [NCH*W-1:0] res;
        res = '0;
        for (int i = 0; i < NCH; i++) begin
            res[i*W +: W] = dv[i*W +: W] ^ pv;
        end
        return res;
    endfunction

    logic [NCH*W-1:0] d_q;
    logic [W-1:0]     p_q;
    logic             v_q;
    logic             mode_q;
    logic             mode_prev_q;
    logic             inv_q;

    logic [NCH*W-1:0] acc_q, acc_d;
    logic [NCH*W-1:0] pout_q, pout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ov_q, ov_d;
    logic             fd_q, fd_d;

    logic [NCH*W-1:0] x_s;
    logic [NCH*W-1:0] inv_mask_s;
    logic [NCH*W-1:0] acc_base_s;
    logic [CW-1:0]    cnt_base_s;
    logic             switch_s;

    // Input stage: capture every beat unconditionally; mode_prev_q tracks mode changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= '0;
            p_q         <= '0;
            v_q         <= 1'b0;
            mode_q      <= 1'b0;
            mode_prev_q <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            d_q         <= d;
            p_q         <= p_in;
            v_q         <= in_valid;
            mode_q      <= mode;
            mode_prev_q <= mode_q;
            inv_q       <= inv;
        end
    end

    // Next-state for the accumulator, beat counter and output word.
    always_comb begin
        x_s        = beat_term(d_q, p_q);
        inv_mask_s = {(NCH*W){inv_q}};
        switch_s   = mode_q ^ mode_prev_q;
        // A mode change drops any partial frame; the current beat starts fresh.
        acc_base_s = switch_s ? '0 : acc_q;
        cnt_base_s = switch_s ? '0 : cnt_q;
        pout_d     = pout_q;
        acc_d      = acc_base_s;
        cnt_d      = cnt_base_s;
        ov_d       = 1'b0;
        fd_d       = 1'b0;
        if (!mode_q) begin
            acc_d = '0;
            cnt_d = '0;
            if (v_q) begin
                pout_d = x_s ^ inv_mask_s;
                ov_d   = 1'b1;
            end else begin
                pout_d = pout_q;
            end
        end else if (v_q) begin
            if (cnt_base_s == LAST_BEAT) begin
                pout_d = acc_base_s ^ x_s ^ inv_mask_s;
                ov_d   = 1'b1;
                fd_d   = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
            end else if (cnt_base_s == '0) begin
                acc_d = x_s;
                cnt_d = cnt_base_s + CW'(1);
            end else begin
                acc_d = acc_base_s ^ x_s;
                cnt_d = cnt_base_s + CW'(1);
            end
        end else begin
            acc_d = acc_base_s;
            cnt_d = cnt_base_s;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            pout_q <= '0;
            ov_q   <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            pout_q <= pout_d;
            ov_q   <= ov_d;
            fd_q   <= fd_d;
        end
    end

    assign pout       = pout_q;
    assign out_valid  = ov_q;
    assign frame_done = fd_q;
    assign beat_cnt   = cnt_q;
endmodule

// File: tb/tb_bptc_parity_pipe.sv
// Self-checking bench: legacy 2x1 instance plus a 4x8 instance checked via a scoreboard.
module tb_bptc_parity_pipe;
    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, mode, inv;
    logic [31:0] d;
    logic [7:0]  p_in;
    logic [31:0] pout;
    logic        out_valid, frame_done;
    logic [1:0]  beat_cnt;

    logic        l_in_valid, l_p, l_mode, l_inv;
    logic [1:0]  l_d;
    logic [1:0]  l_pout;
    logic        l_out_valid, l_frame_done;
    logic [1:0]  l_beat_cnt;

    bptc_parity_pipe #(.NCH(4), .W(8), .FRAME_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d(d), .p_in(p_in),
        .mode(mode), .inv(inv), .pout(pout), .out_valid(out_valid),
        .frame_done(frame_done), .beat_cnt(beat_cnt)
    );

    bptc_parity_pipe dut_legacy (
        .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .d(l_d), .p_in(l_p),
        .mode(l_mode), .inv(l_inv), .pout(l_pout), .out_valid(l_out_valid),
        .frame_done(l_frame_done), .beat_cnt(l_beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pout;
        logic        fd;
        int          due;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [7:0]  p;
        logic        iv;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0] d;
        logic       p;
        logic [1:0] exp;
    } lvec_t;

    exp_t        sbq[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    logic [31:0] hold = 32'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic drive(input logic v, input logic [31:0] dd, input logic [7:0] pp,
                         input logic m, input logic iv);
        in_valid = v; d = dd; p_in = pp; mode = m; inv = iv;
    endtask

    task automatic expect_out(input logic [31:0] pv, input logic fdv);
        sbq.push_back('{pout: pv, fd: fdv, due: cyc + 2});
    endtask

    // Advance one clock and check the main instance against the scoreboard.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("pout", 64'(pout), 64'(e.pout));
                chk("frame_done", 64'(frame_done), 64'(e.fd));
                chk("latency", 64'(cyc), 64'(e.due));
                hold = e.pout;
            end
        end else begin
            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                chk("missing_out_valid", 64'(out_valid), 64'd1);
                void'(sbq.pop_front());
            end
            chk("pout_hold", 64'(pout), 64'(hold));
            chk("frame_done_idle", 64'(frame_done), 64'd0);
        end
    endtask

    vec_t  tbl[8];
    lvec_t ltbl[8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            ltbl[i].d   = 2'(i >> 1);
            ltbl[i].p   = 1'(i);
            ltbl[i].exp = {ltbl[i].d[1] ^ ltbl[i].p, ltbl[i].d[0] ^ ltbl[i].p};
        end
        tbl[0] = '{1'b1, 32'h12345678, 8'hFF, 1'b1, 32'h12345678};
        tbl[1] = '{1'b0, 32'h00000000, 8'h00, 1'b0, 32'h00000000};
        tbl[2] = '{1'b1, 32'h00000000, 8'hA5, 1'b0, 32'hA5A5A5A5};
        tbl[3] = '{1'b1, 32'hFFFF0000, 8'h0F, 1'b0, 32'hF0F00F0F};
        tbl[4] = '{1'b1, 32'hDEADBEEF, 8'h00, 1'b1, 32'h21524110};
        tbl[5] = '{1'b0, 32'hFFFFFFFF, 8'hFF, 1'b1, 32'h00000000};
        tbl[6] = '{1'b1, 32'h13579BDF, 8'h11, 1'b0, 32'h02468ACE};
        tbl[7] = '{1'b1, 32'hCAFEF00D, 8'h55, 1'b1, 32'h60545AA7};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        l_in_valid = 1'b0; l_d = 2'b00; l_p = 1'b0; l_mode = 1'b0; l_inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pout", 64'(pout), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_legacy_pout", 64'(l_pout), 64'd0);
        #3 rst_n = 1'b1;

        // Legacy 2-channel, 1-bit equivalence: all 8 {D2,D1,P} combinations.
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                l_in_valid = 1'b1; l_d = ltbl[j].d; l_p = ltbl[j].p;
            end else begin
                l_in_valid = 1'b0;
            end
            cycle();
            if (j >= 1 && j <= 8) begin
                chk("legacy_out_valid", 64'(l_out_valid), 64'd1);
                chk("legacy_pout", 64'(l_pout), 64'(ltbl[j-1].exp));
            end else if (j == 9) begin
                chk("legacy_idle_valid", 64'(l_out_valid), 64'd0);
                chk("legacy_hold", 64'(l_pout), 64'(ltbl[7].exp));
            end
            chk("legacy_frame_done", 64'(l_frame_done), 64'd0);
        end

        // Wide per-beat parity with inversion and gaps.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].p, 1'b0, tbl[i].iv);
            if (tbl[i].v) expect_out(tbl[i].exp, 1'b0);
            cycle();
            chk("mode0_beat_cnt", 64'(beat_cnt), 64'd0);
        end
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        repeat (3) cycle();

        // Frame accumulate with an idle gap: beat_cnt 1,2,2,3,0.
        drive(1'b1, 32'h00000001, 8'h00, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h00000002, 8'h00, 1'b1, 1'b0); cycle();
        chk("frame_cnt_a", 64'(beat_cnt), 64'd1);
        drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0); cycle();
        chk("frame_cnt_b", 64'(beat_cnt), 64'd2);
        drive(1'b1, 32'h00000004, 8'h00, 1'b1, 1'b0); cycle();
        chk("frame_cnt_c", 64'(beat_cnt), 64'd2);
        drive(1'b1, 32'h00000008, 8'h00, 1'b1, 1'b0); expect_out(32'h0000000F, 1'b1); cycle();
        chk("frame_cnt_d", 64'(beat_cnt), 64'd3);
        drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0); cycle();
        chk("frame_cnt_e", 64'(beat_cnt), 64'd0);

        // Pivot cancels over an even frame; inversion only from the final beat.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h0, 8'hA5, 1'b1, 1'b0);
            if (k == 3) expect_out(32'h00000000, 1'b1);
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h0, 8'hA5, 1'b1, (k == 3));
            if (k == 3) expect_out(32'hFFFFFFFF, 1'b1);
            cycle();
        end
        drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        repeat (2) cycle();

        // Mode switch mid-frame discards the partial frame.
        drive(1'b1, 32'h000000FF, 8'h00, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h0000000F, 8'h00, 1'b1, 1'b0); cycle();
        chk("switch_cnt_a", 64'(beat_cnt), 64'd1);
        drive(1'b1, 32'h0000003C, 8'h00, 1'b0, 1'b0); expect_out(32'h0000003C, 1'b0); cycle();
        chk("switch_cnt_b", 64'(beat_cnt), 64'd2);
        drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0); cycle();
        chk("switch_cnt_c", 64'(beat_cnt), 64'd0);
        drive(1'b1, 32'h00000077, 8'h00, 1'b1, 1'b0); cycle();
        drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0); cycle();
        chk("switch_restart_cnt", 64'(beat_cnt), 64'd1);
        drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        repeat (2) cycle();

        // Async reset mid-frame after 3 beats.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h01020304, 8'h5A, 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        chk("pre_reset_cnt", 64'(beat_cnt), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pout", 64'(pout), 64'd0);
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_fd", 64'(frame_done), 64'd0);
        chk("async_rst_cnt", 64'(beat_cnt), 64'd0);
        sbq.delete();
        hold = 32'h0;
        #1 rst_n = 1'b1;
        drive(1'b1, 32'h11111111, 8'h03, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h22222222, 8'h03, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h44444444, 8'h03, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h88888888, 8'h03, 1'b1, 1'b0); expect_out(32'hFFFFFFFF, 1'b1); cycle();
        chk("post_reset_cnt", 64'(beat_cnt), 64'd3);
        drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        repeat (3) cycle();

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
